// File: rtl/tlb_fill_ctrl_if.sv
// Bundle of the miss, page-walk and TLB-table signals around tlb_fill_ctrl.
// master: the fill controller; slave: the pipeline/walker/TLB side.
interface tlb_fill_ctrl_if;
    logic         tlb_miss;
    logic [19:0]  lookup_vpn;
    logic         flush;
    logic         walk_req;
    logic [19:0]  walk_vpn;
    logic         walk_ack;
    logic         walk_err;
    logic [19:0]  walk_pf;
    logic         walk_p;
    logic         walk_rw;
    logic         walk_pcd;
    logic [159:0] VP;
    logic [159:0] PF;
    logic [7:0]   entry_v;
    logic [7:0]   entry_P;
    logic [7:0]   entry_RW;
    logic [7:0]   entry_PCD;
    logic         stall;
    logic         fill_done;
    logic         page_fault;

    modport master (
        input  tlb_miss, lookup_vpn, flush,
        input  walk_ack, walk_err, walk_pf, walk_p, walk_rw, walk_pcd,
        output walk_req, walk_vpn,
        output VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
        output stall, fill_done, page_fault
    );

    modport slave (
        output tlb_miss, lookup_vpn, flush,
        output walk_ack, walk_err, walk_pf, walk_p, walk_rw, walk_pcd,
        input  walk_req, walk_vpn,
        input  VP, PF, entry_v, entry_P, entry_RW, entry_PCD,
        input  stall, fill_done, page_fault
    );
endinterface

// File: rtl/tlb_fill_ctrl.sv
// tlb_fill_ctrl: owns the 8-entry TLB table and sequences a miss through
// page walk, victim fill and pipeline release; also services table flushes.
module tlb_fill_ctrl #(
    parameter int WALK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    tlb_fill_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, WALK, FILL, DONE} state_t;

    // Counter value on the last WALK cycle that may still accept an ack.
    localparam logic [7:0] TMO_LAST = 8'(WALK_TIMEOUT - 1);

    state_t       r_state;
    logic [19:0]  r_walk_vpn;
    logic         r_walk_req;
    logic         r_fill_done;
    logic         r_page_fault;
    logic [2:0]   r_victim;
    logic         r_alloc;
    logic [2:0]   r_rr_ptr;
    logic [7:0]   r_tmo_cnt;
    logic [19:0]  r_cap_pf;
    logic         r_cap_p;
    logic         r_cap_rw;
    logic         r_cap_pcd;
    logic [19:0]  r_vp [8];
    logic [19:0]  r_pf [8];
    logic [7:0]   r_v;
    logic [7:0]   r_p;
    logic [7:0]   r_rw;
    logic [7:0]   r_pcd;

    logic         w_hit;
    logic [2:0]   w_hit_idx;
    logic [159:0] w_vp_flat;
    logic [159:0] w_pf_flat;

    // Find a valid entry already holding the missing VPN; lowest index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_v[i] && (r_vp[i] == bus.lookup_vpn)) begin
                w_hit     = 1'b1;
                w_hit_idx = 3'(i);
            end
        end
    end

    // Control FSM plus the entry table it owns; flush overrides every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_walk_vpn   <= '0;
            r_walk_req   <= 1'b0;
            r_fill_done  <= 1'b0;
            r_page_fault <= 1'b0;
            r_victim     <= '0;
            r_alloc      <= 1'b0;
            r_rr_ptr     <= '0;
            r_tmo_cnt    <= '0;
            r_cap_pf     <= '0;
            r_cap_p      <= 1'b0;
            r_cap_rw     <= 1'b0;
            r_cap_pcd    <= 1'b0;
            r_v          <= '0;
            r_p          <= '0;
            r_rw         <= '0;
            r_pcd        <= '0;
            for (int i = 0; i < 8; i++) begin
                r_vp[i] <= '0;
                r_pf[i] <= '0;
            end
        end else begin
            r_fill_done  <= 1'b0;
            r_page_fault <= 1'b0;
            if (bus.flush) begin
                // Any pending walk result or fill is dropped silently.
                r_v        <= '0;
                r_rr_ptr   <= '0;
                r_walk_req <= 1'b0;
                r_state    <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.tlb_miss) begin
                            r_walk_vpn <= bus.lookup_vpn;
                            r_tmo_cnt  <= '0;
                            r_walk_req <= 1'b1;
                            if (w_hit) begin
                                r_victim <= w_hit_idx;
                                r_alloc  <= 1'b0;
                            end else begin
                                r_victim <= r_rr_ptr;
                                r_alloc  <= 1'b1;
                            end
                            r_state <= WALK;
                        end
                    end
                    WALK: begin
                        if (bus.walk_ack) begin
                            r_walk_req <= 1'b0;
                            if (bus.walk_err) begin
                                r_page_fault <= 1'b1;
                                r_state      <= IDLE;
                            end else begin
                                r_cap_pf  <= bus.walk_pf;
                                r_cap_p   <= bus.walk_p;
                                r_cap_rw  <= bus.walk_rw;
                                r_cap_pcd <= bus.walk_pcd;
                                r_state   <= FILL;
                            end
                        end else if (r_tmo_cnt == TMO_LAST) begin
                            r_walk_req   <= 1'b0;
                            r_page_fault <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        end
                    end
                    FILL: begin
                        r_vp[r_victim]  <= r_walk_vpn;
                        r_pf[r_victim]  <= r_cap_pf;
                        r_v[r_victim]   <= 1'b1;
                        r_p[r_victim]   <= r_cap_p;
                        r_rw[r_victim]  <= r_cap_rw;
                        r_pcd[r_victim] <= r_cap_pcd;
                        if (r_alloc) begin
                            r_rr_ptr <= r_rr_ptr + 3'd1;
                        end
                        r_fill_done <= 1'b1;
                        r_state     <= DONE;
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Flatten the entry arrays onto the TLB's 160-bit buses.
    always_comb begin
        w_vp_flat = '0;
        w_pf_flat = '0;
        for (int i = 0; i < 8; i++) begin
            w_vp_flat[20*i +: 20] = r_vp[i];
            w_pf_flat[20*i +: 20] = r_pf[i];
        end
    end

    assign bus.VP         = w_vp_flat;
    assign bus.PF         = w_pf_flat;
    assign bus.entry_v    = r_v;
    assign bus.entry_P    = r_p;
    assign bus.entry_RW   = r_rw;
    assign bus.entry_PCD  = r_pcd;
    assign bus.walk_req   = r_walk_req;
    assign bus.walk_vpn   = r_walk_vpn;
    assign bus.fill_done  = r_fill_done;
    assign bus.page_fault = r_page_fault;
    // Stall is combinational on the miss in IDLE so the requester holds at once.
    assign bus.stall = ((r_state == IDLE) && bus.tlb_miss && !bus.flush)
                     || (r_state == WALK) || (r_state == FILL);
endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// Directed bench for tlb_fill_ctrl: a table of miss transactions with
// hand-computed table contents, then timeout, flush and reset sequences.
module tb_tlb_fill_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    tlb_fill_ctrl_if bus ();

    tlb_fill_ctrl #(.WALK_TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [19:0] vpn;
        logic [19:0] pf;
        logic        p;
        logic        rw;
        logic        pcd;
        logic        err;
        int          ack;
        int          idx;
        logic [7:0]  ev;
        logic [7:0]  ep;
        logic [7:0]  erw;
        logic [7:0]  epcd;
        bit          ok;
    } vec_t;

    vec_t        vecs [19];
    logic        g_stall_miss;
    logic        g_walk_req;
    logic [19:0] g_walk_vpn;
    logic        g_stall_after;
    int          n_done;
    int          n_fault;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.tlb_miss = 1'b0;
        bus.flush    = 1'b0;
        bus.walk_ack = 1'b0;
        bus.walk_err = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issue one miss from IDLE, ack on WALK cycle v.ack, and watch three more cycles.
    task automatic run_miss(input vec_t v);
        bus.lookup_vpn = v.vpn;
        bus.tlb_miss   = 1'b1;
        @(negedge clk);
        g_stall_miss = bus.stall;
        @(posedge clk);
        #1;
        bus.tlb_miss = 1'b0;
        n_done  = 0;
        n_fault = 0;
        for (int c = 1; c <= v.ack; c++) begin
            if (c == v.ack) begin
                bus.walk_ack = 1'b1;
                bus.walk_err = v.err;
                bus.walk_pf  = v.pf;
                bus.walk_p   = v.p;
                bus.walk_rw  = v.rw;
                bus.walk_pcd = v.pcd;
            end
            @(negedge clk);
            if (c == 1) begin
                g_walk_req = bus.walk_req;
                g_walk_vpn = bus.walk_vpn;
            end
            n_done  += int'(bus.fill_done);
            n_fault += int'(bus.page_fault);
            @(posedge clk);
            #1;
            bus.walk_ack = 1'b0;
            bus.walk_err = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) g_stall_after = bus.stall;
            n_done  += int'(bus.fill_done);
            n_fault += int'(bus.page_fault);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        if (v.rst) do_reset();
        run_miss(v);
        chk({tag, "_stall_miss"}, 160'(g_stall_miss), 160'(1'b1));
        chk({tag, "_walk_req"}, 160'(g_walk_req), 160'(1'b1));
        chk({tag, "_walk_vpn"}, 160'(g_walk_vpn), 160'(v.vpn));
        chk({tag, "_fill_done_cnt"}, 160'(n_done), v.ok ? 160'(1) : 160'(0));
        chk({tag, "_fault_cnt"}, 160'(n_fault), v.ok ? 160'(0) : 160'(1));
        chk({tag, "_stall_after_ack"}, 160'(g_stall_after), 160'(v.ok));
        chk({tag, "_entry_v"}, 160'(bus.entry_v), 160'(v.ev));
        chk({tag, "_entry_P"}, 160'(bus.entry_P), 160'(v.ep));
        chk({tag, "_entry_RW"}, 160'(bus.entry_RW), 160'(v.erw));
        chk({tag, "_entry_PCD"}, 160'(bus.entry_PCD), 160'(v.epcd));
        if (v.ok) begin
            chk({tag, "_VP"}, 160'(bus.VP[20*v.idx +: 20]), 160'(v.vpn));
            chk({tag, "_PF"}, 160'(bus.PF[20*v.idx +: 20]), 160'(v.pf));
        end
    endtask

    initial begin
        int   cnt;
        vec_t hv;

        //            rst  vpn       pf        p     rw    pcd   err   ack idx ev     ep     erw    epcd   ok
        vecs[0]  = '{1'b1, 20'h03000, 20'h00003, 1'b1, 1'b1, 1'b1, 1'b0, 2, 0, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1};
        vecs[1]  = '{1'b1, 20'h00000, 20'h00100, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 8'h01, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 20'h01000, 20'h00101, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1, 8'h03, 8'h03, 8'h02, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 20'h02000, 20'h00102, 1'b0, 1'b1, 1'b1, 1'b0, 4, 2, 8'h07, 8'h03, 8'h06, 8'h04, 1'b1};
        vecs[4]  = '{1'b0, 20'h03000, 20'h00103, 1'b1, 1'b0, 1'b1, 1'b0, 1, 3, 8'h0F, 8'h0B, 8'h06, 8'h0C, 1'b1};
        vecs[5]  = '{1'b0, 20'h04000, 20'h00104, 1'b1, 1'b1, 1'b1, 1'b0, 2, 4, 8'h1F, 8'h1B, 8'h16, 8'h1C, 1'b1};
        vecs[6]  = '{1'b0, 20'h05000, 20'h00105, 1'b0, 1'b0, 1'b0, 1'b0, 1, 5, 8'h3F, 8'h1B, 8'h16, 8'h1C, 1'b1};
        vecs[7]  = '{1'b0, 20'h06000, 20'h00106, 1'b1, 1'b0, 1'b0, 1'b0, 1, 6, 8'h7F, 8'h5B, 8'h16, 8'h1C, 1'b1};
        vecs[8]  = '{1'b0, 20'h07000, 20'h00107, 1'b0, 1'b1, 1'b0, 1'b0, 2, 7, 8'hFF, 8'h5B, 8'h96, 8'h1C, 1'b1};
        vecs[9]  = '{1'b0, 20'h08000, 20'h00108, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 8'hFF, 8'h5B, 8'h97, 8'h1C, 1'b1};
        vecs[10] = '{1'b0, 20'h09000, 20'h00109, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 8'hFF, 8'h5B, 8'h95, 8'h1E, 1'b1};
        vecs[11] = '{1'b1, 20'h00000, 20'h00200, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 20'h01000, 20'h00201, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 8'h03, 8'h03, 8'h01, 8'h02, 1'b1};
        vecs[13] = '{1'b0, 20'h02000, 20'h00202, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 8'h07, 8'h03, 8'h01, 8'h06, 1'b1};
        vecs[14] = '{1'b0, 20'h0b000, 20'h0020b, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3, 8'h0F, 8'h03, 8'h09, 8'h06, 1'b1};
        vecs[15] = '{1'b0, 20'h0b000, 20'h0030b, 1'b1, 1'b0, 1'b1, 1'b0, 2, 3, 8'h0F, 8'h0B, 8'h01, 8'h0E, 1'b1};
        vecs[16] = '{1'b0, 20'h0c000, 20'h0020c, 1'b1, 1'b1, 1'b1, 1'b0, 1, 4, 8'h1F, 8'h1B, 8'h11, 8'h1E, 1'b1};
        vecs[17] = '{1'b0, 20'h0d000, 20'h00fff, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 8'h1F, 8'h1B, 8'h11, 8'h1E, 1'b0};
        vecs[18] = '{1'b0, 20'h0d000, 20'h0020d, 1'b1, 1'b0, 1'b0, 1'b0, 1, 5, 8'h3F, 8'h3B, 8'h11, 8'h1E, 1'b1};

        bus.tlb_miss   = 1'b0;
        bus.lookup_vpn = '0;
        bus.flush      = 1'b0;
        bus.walk_ack   = 1'b0;
        bus.walk_err   = 1'b0;
        bus.walk_pf    = '0;
        bus.walk_p     = 1'b0;
        bus.walk_rw    = 1'b0;
        bus.walk_pcd   = 1'b0;
        reset_n        = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_walk_req", 160'(bus.walk_req), 160'(0));
        chk("rst_walk_vpn", 160'(bus.walk_vpn), 160'(0));
        chk("rst_VP", bus.VP, 160'(0));
        chk("rst_PF", bus.PF, 160'(0));
        chk("rst_flags", 160'({bus.entry_v, bus.entry_P, bus.entry_RW, bus.entry_PCD}), 160'(0));
        chk("rst_pulses", 160'({bus.stall, bus.fill_done, bus.page_fault}), 160'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            apply_vec($sformatf("row%0d", i), vecs[i]);
        end

        // Timeout with no ack: fault in the cycle after 4 WALK cycles.
        do_reset();
        bus.lookup_vpn = 20'h0e000;
        bus.tlb_miss   = 1'b1;
        @(posedge clk);
        #1;
        bus.tlb_miss = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("to_req_c%0d", c), 160'(bus.walk_req), 160'(1));
            chk($sformatf("to_fault_early_c%0d", c), 160'(bus.page_fault), 160'(0));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("to_fault", 160'(bus.page_fault), 160'(1));
        chk("to_req_drop", 160'(bus.walk_req), 160'(0));
        chk("to_stall", 160'(bus.stall), 160'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("to_fault_width", 160'(bus.page_fault), 160'(0));
        chk("to_entry_v", 160'(bus.entry_v), 160'(0));
        @(posedge clk);
        #1;

        // Flush and walk_ack on the same edge, then a late ack in IDLE.
        hv = '{1'b1, 20'h10000, 20'h00310, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        apply_vec("fl_pre", hv);
        bus.lookup_vpn = 20'h11000;
        bus.tlb_miss   = 1'b1;
        @(posedge clk);
        #1;
        bus.tlb_miss = 1'b0;
        bus.walk_ack = 1'b1;
        bus.walk_pf  = 20'h00311;
        bus.walk_p   = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.walk_ack = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        chk("fl_entry_v", 160'(bus.entry_v), 160'(0));
        chk("fl_walk_req", 160'(bus.walk_req), 160'(0));
        chk("fl_stall", 160'(bus.stall), 160'(0));
        chk("fl_fill_done", 160'(bus.fill_done), 160'(0));
        @(posedge clk);
        #1;
        bus.walk_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.walk_ack = 1'b0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cnt += int'(bus.fill_done) + int'(bus.page_fault) + int'(bus.walk_req) + int'(bus.stall);
            @(posedge clk);
            #1;
        end
        chk("late_ack_activity", 160'(cnt), 160'(0));
        chk("late_ack_entry_v", 160'(bus.entry_v), 160'(0));

        // Flush during FILL suppresses the write and fill_done.
        bus.lookup_vpn = 20'h12000;
        bus.tlb_miss   = 1'b1;
        @(posedge clk);
        #1;
        bus.tlb_miss = 1'b0;
        bus.walk_ack = 1'b1;
        bus.walk_pf  = 20'h00312;
        @(posedge clk);
        #1;
        bus.walk_ack = 1'b0;
        @(negedge clk);
        chk("ff_stall_in_fill", 160'(bus.stall), 160'(1));
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        cnt = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            cnt += int'(bus.fill_done) + int'(bus.page_fault);
            @(posedge clk);
            #1;
        end
        chk("ff_pulses", 160'(cnt), 160'(0));
        chk("ff_entry_v", 160'(bus.entry_v), 160'(0));

        // Flush reset rr_ptr, so the next new VPN lands in entry 0.
        hv = '{1'b0, 20'h14000, 20'h00314, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1};
        apply_vec("fl_post", hv);

        // Reset asserted mid-walk clears outputs before the next clock edge.
        bus.lookup_vpn = 20'h13000;
        bus.tlb_miss   = 1'b1;
        @(posedge clk);
        #1;
        bus.tlb_miss = 1'b0;
        @(negedge clk);
        chk("rm_req_before", 160'(bus.walk_req), 160'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_walk_req", 160'(bus.walk_req), 160'(0));
        chk("rm_stall", 160'(bus.stall), 160'(0));
        chk("rm_entry_v", 160'(bus.entry_v), 160'(0));
        chk("rm_VP", bus.VP, 160'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        hv = '{1'b0, 20'h15000, 20'h00315, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 1'b1};
        apply_vec("rm_post", hv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
